// File: rtl/encoder_ctrl_pkg.sv
// Shared types and arithmetic for the encoder parameter controller.
package encoder_ctrl_pkg;

   typedef enum logic {MODE_BROWSE, MODE_EDIT} mode_t;

   typedef enum logic [1:0] {EVT_NONE, EVT_SHORT, EVT_LONG} btn_evt_t;

   localparam int unsigned CalcW = 32;

   // Saturating add (clamped to max_val) or subtract (clamped to zero).
   function automatic logic [CalcW-1:0] clamp_step(input logic [CalcW-1:0] val,
                                                   input logic [CalcW-1:0] delta,
                                                   input logic             up,
                                                   input logic [CalcW-1:0] max_val);
      logic [CalcW:0] sum;
      sum = {1'b0, val} + {1'b0, delta};
      if (up) begin
         clamp_step = (sum > {1'b0, max_val}) ? max_val : sum[CalcW-1:0];
      end else begin
         clamp_step = (val < delta) ? '0 : val - delta;
      end
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end: synchroniser, debounce filter and short/long press classifier.
module button_debounce
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC   = 16,
   parameter int unsigned LONG_PRESS_CYC = 1000
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     btn_raw,
   output btn_evt_t btn_evt
);

   localparam int unsigned DebW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned HoldW = $clog2(LONG_PRESS_CYC + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             prev_q;
   logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic [HoldW-1:0] hold_q, hold_d;

   always_comb begin
      level_d   = level_q;
      deb_cnt_d = '0;
      if (sync2_q != level_q) begin
         if (deb_cnt_q == DebW'(DEBOUNCE_CYC - 1)) begin
            level_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
         end
      end
   end

   // hold_q counts debounced-high cycles, saturating once the long threshold is reached
   always_comb begin
      hold_d = hold_q;
      if (!level_q) begin
         hold_d = '0;
      end else if (hold_q != HoldW'(LONG_PRESS_CYC)) begin
         hold_d = hold_q + HoldW'(1);
      end
   end

   always_comb begin
      btn_evt = EVT_NONE;
      if (level_q && (hold_q == HoldW'(LONG_PRESS_CYC - 1))) begin
         btn_evt = EVT_LONG;
      end else if (!level_q && prev_q && (hold_q != HoldW'(LONG_PRESS_CYC))) begin
         btn_evt = EVT_SHORT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         prev_q    <= 1'b0;
         deb_cnt_q <= '0;
         hold_q    <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         prev_q    <= level_q;
         deb_cnt_q <= deb_cnt_d;
         hold_q    <= hold_d;
      end
   end

endmodule

// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter editor: browse/select registers, edit with clamping and acceleration.
module encoder_param_ctrl
   import encoder_ctrl_pkg::*;
#(
   parameter int unsigned N_PARAMS       = 4,
   parameter int unsigned VAL_W          = 8,
   parameter int unsigned MAX_VAL        = 255,
   parameter int unsigned DEFAULT_VAL    = 0,
   parameter int unsigned DEBOUNCE_CYC   = 16,
   parameter int unsigned LONG_PRESS_CYC = 1000,
   parameter int unsigned FAST_WIN_CYC   = 64,
   parameter int unsigned ACCEL          = 4,
   parameter int unsigned TIMEOUT_CYC    = 4096
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         step_valid,
   input  logic                         step_dir,
   input  logic                         btn_raw,
   output logic [$clog2(N_PARAMS)-1:0]  sel,
   output logic                         edit_mode,
   output logic [VAL_W-1:0]             sel_value,
   output logic [N_PARAMS*VAL_W-1:0]    param_bus,
   output logic                         value_changed
);

   localparam int unsigned SelW = $clog2(N_PARAMS);
   localparam int unsigned GapW = (FAST_WIN_CYC > 0) ? $clog2(FAST_WIN_CYC + 1) : 1;
   localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   btn_evt_t        btn_evt;
   mode_t           mode_q, mode_d;
   logic [SelW-1:0] sel_q, sel_d;
   logic [VAL_W-1:0] params_q [N_PARAMS];
   logic [VAL_W-1:0] params_d [N_PARAMS];
   logic [GapW-1:0] gap_q, gap_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            vc_q, vc_d;
   logic [VAL_W-1:0] cur_val, stepped_val;
   logic [CalcW-1:0] delta;

   button_debounce #(
      .DEBOUNCE_CYC   (DEBOUNCE_CYC),
      .LONG_PRESS_CYC (LONG_PRESS_CYC)
   ) u_button_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw),
      .btn_evt (btn_evt)
   );

   assign cur_val     = params_q[sel_q];
   assign delta       = (gap_q < GapW'(FAST_WIN_CYC)) ? CalcW'(ACCEL) : CalcW'(1);
   assign stepped_val = VAL_W'(clamp_step(CalcW'(cur_val), delta, step_dir, CalcW'(MAX_VAL)));

   always_comb begin
      params_d = params_q;
      sel_d    = sel_q;
      mode_d   = mode_q;
      vc_d     = 1'b0;
      gap_d    = (gap_q == GapW'(FAST_WIN_CYC)) ? gap_q : gap_q + GapW'(1);
      tmo_d    = ((mode_q == MODE_EDIT) && (TIMEOUT_CYC != 0)) ? tmo_q + TmoW'(1) : '0;

      // Button events take priority; a coincident step is dropped.
      unique case (btn_evt)
         EVT_SHORT: begin
            tmo_d = '0;
            if (mode_q == MODE_BROWSE) begin
               mode_d = MODE_EDIT;
               gap_d  = GapW'(FAST_WIN_CYC);
            end else begin
               mode_d = MODE_BROWSE;
            end
         end
         EVT_LONG: begin
            tmo_d           = '0;
            params_d[sel_q] = VAL_W'(DEFAULT_VAL);
            vc_d            = (cur_val != VAL_W'(DEFAULT_VAL));
         end
         default: begin
            if (step_valid) begin
               tmo_d = '0;
               if (mode_q == MODE_BROWSE) begin
                  sel_d = step_dir ? sel_q + SelW'(1) : sel_q - SelW'(1);
               end else begin
                  gap_d           = '0;
                  params_d[sel_q] = stepped_val;
                  vc_d            = (stepped_val != cur_val);
               end
            end else if ((mode_q == MODE_EDIT) && (TIMEOUT_CYC != 0) &&
                         (tmo_q == TmoW'(TIMEOUT_CYC - 1))) begin
               mode_d = MODE_BROWSE;
               tmo_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_BROWSE;
         sel_q  <= '0;
         gap_q  <= GapW'(FAST_WIN_CYC);
         tmo_q  <= '0;
         vc_q   <= 1'b0;
         for (int i = 0; i < int'(N_PARAMS); i++) begin
            params_q[i] <= VAL_W'(DEFAULT_VAL);
         end
      end else begin
         mode_q   <= mode_d;
         sel_q    <= sel_d;
         gap_q    <= gap_d;
         tmo_q    <= tmo_d;
         vc_q     <= vc_d;
         params_q <= params_d;
      end
   end

   for (genvar gi = 0; gi < int'(N_PARAMS); gi++) begin : g_bus
      assign param_bus[gi*VAL_W +: VAL_W] = params_q[gi];
   end

   assign sel           = sel_q;
   assign edit_mode     = (mode_q == MODE_EDIT);
   assign sel_value     = params_q[sel_q];
   assign value_changed = vc_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Self-checking bench for encoder_param_ctrl against a timestamp-based behavioural model.
module tb_encoder_param_ctrl;

   localparam int N     = 4;
   localparam int VW    = 8;
   localparam int MAXV  = 255;
   localparam int DEF   = 0;
   localparam int DEB   = 16;
   localparam int LONGC = 1000;
   localparam int FAST  = 64;
   localparam int ACC   = 4;
   localparam int TMO   = 200;
   localparam int HIST  = 65536;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          step_valid = 1'b0;
   logic          step_dir = 1'b0;
   logic          btn_raw = 1'b0;
   logic [1:0]    sel;
   logic          edit_mode;
   logic [VW-1:0] sel_value;
   logic [N*VW-1:0] param_bus;
   logic          value_changed;

   always #5 clk = ~clk;

   encoder_param_ctrl #(
      .N_PARAMS       (N),
      .VAL_W          (VW),
      .MAX_VAL        (MAXV),
      .DEFAULT_VAL    (DEF),
      .DEBOUNCE_CYC   (DEB),
      .LONG_PRESS_CYC (LONGC),
      .FAST_WIN_CYC   (FAST),
      .ACCEL          (ACC),
      .TIMEOUT_CYC    (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .step_valid    (step_valid),
      .step_dir      (step_dir),
      .btn_raw       (btn_raw),
      .sel           (sel),
      .edit_mode     (edit_mode),
      .sel_value     (sel_value),
      .param_bus     (param_bus),
      .value_changed (value_changed)
   );

   int tests = 0;
   int fails = 0;

   // Model state: everything keyed on absolute cycle numbers since reset release.
   int cyc;
   bit raw_hist [HIST];
   bit btn_lvl;
   bit m_lvl;
   int m_rise;
   int m_sel;
   bit m_edit;
   int m_params [N];
   int m_last_act;
   int m_last_step;
   bit m_have_step;
   bit m_vc;
   int dut_vc_cnt;
   int mod_vc_cnt;

   function automatic void model_reset();
      cyc = 0;
      for (int i = 0; i < HIST; i++) raw_hist[i] = 1'b0;
      m_lvl = 1'b0;
      m_rise = -100000;
      m_sel = 0;
      m_edit = 1'b0;
      for (int i = 0; i < N; i++) m_params[i] = DEF;
      m_last_act = 0;
      m_last_step = 0;
      m_have_step = 1'b0;
      m_vc = 1'b0;
      dut_vc_cnt = 0;
      mod_vc_cnt = 0;
   endfunction

   function automatic bit synced_at(int c);
      return (c >= 2) ? raw_hist[c-2] : 1'b0;
   endfunction

   function automatic logic [N*VW-1:0] model_bus();
      logic [N*VW-1:0] b;
      for (int i = 0; i < N; i++) b[i*VW +: VW] = VW'(m_params[i]);
      return b;
   endfunction

   // Drive one cycle of stimulus, advance the model, and land 1 time unit after the edge.
   task automatic tick(input bit sv, input bit dir);
      bit lvl, flip;
      int evt, d, v, nv;
      step_valid = sv;
      step_dir   = dir;
      btn_raw    = btn_lvl;
      if (cyc < HIST) raw_hist[cyc] = btn_lvl;
      // Level flips once the synchronised input has disagreed for DEB whole cycles.
      flip = (cyc >= DEB);
      for (int i = 1; i <= DEB; i++) if (synced_at(cyc - i) == m_lvl) flip = 1'b0;
      lvl = flip ? !m_lvl : m_lvl;
      if (lvl && !m_lvl) m_rise = cyc;
      evt = 0;
      if (lvl && (cyc - m_rise == LONGC - 1)) evt = 2;
      else if (!lvl && m_lvl && (cyc - m_rise < LONGC)) evt = 1;
      m_lvl = lvl;
      m_vc = 1'b0;
      if (evt == 1) begin
         m_edit = !m_edit;
         m_have_step = 1'b0;
         m_last_act = cyc;
      end else if (evt == 2) begin
         m_vc = (m_params[m_sel] != DEF);
         m_params[m_sel] = DEF;
         m_last_act = cyc;
      end else if (sv) begin
         m_last_act = cyc;
         if (!m_edit) begin
            m_sel = (m_sel + (dir ? 1 : N - 1)) % N;
         end else begin
            d = (m_have_step && (cyc - m_last_step <= FAST)) ? ACC : 1;
            v = m_params[m_sel];
            if (dir) nv = (v + d > MAXV) ? MAXV : v + d;
            else     nv = (v < d) ? 0 : v - d;
            m_vc = (nv != v);
            m_params[m_sel] = nv;
            m_last_step = cyc;
            m_have_step = 1'b1;
         end
      end else if (m_edit && (cyc == m_last_act + TMO)) begin
         m_edit = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      step_valid = 1'b0;
      if (value_changed === 1'b1) dut_vc_cnt++;
      if (m_vc) mod_vc_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic press(input int hold);
      btn_lvl = 1'b1;
      idle(hold);
      btn_lvl = 1'b0;
      idle(40);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      btn_lvl = 1'b0;
      btn_raw = 1'b0;
      step_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d expected 0", sel); end
      tests++; if (edit_mode !== 1'b0) begin fails++; $display("FAIL reset_mode: got %b expected 0", edit_mode); end
      tests++; if (sel_value !== VW'(DEF)) begin fails++; $display("FAIL reset_selval: got %0d expected %0d", sel_value, DEF); end
      tests++; if (param_bus !== model_bus()) begin fails++; $display("FAIL reset_bus: got %h expected %h", param_bus, model_bus()); end
      tests++; if (value_changed !== 1'b0) begin fails++; $display("FAIL reset_vc: got %b expected 0", value_changed); end
   endtask

   task automatic test_browse();
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 1'b1);
         tests++; if (sel !== m_sel[1:0]) begin fails++; $display("FAIL browse_sel%0d: got %0d expected %0d", k, sel, m_sel); end
         idle(99);
      end
      tests++; if (param_bus !== model_bus()) begin fails++; $display("FAIL browse_bus: got %h expected %h", param_bus, model_bus()); end
      tests++; if (dut_vc_cnt !== mod_vc_cnt) begin fails++; $display("FAIL browse_vc: got %0d pulses expected %0d", dut_vc_cnt, mod_vc_cnt); end
   endtask

   task automatic test_short_edit();
      press(50);
      tests++; if (edit_mode !== m_edit) begin fails++; $display("FAIL short_mode: got %b expected %b", edit_mode, m_edit); end
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b1);
         tests++; if (sel_value !== VW'(m_params[m_sel])) begin fails++; $display("FAIL edit_inc%0d: got %0d expected %0d", k, sel_value, m_params[m_sel]); end
         tests++; if (value_changed !== m_vc) begin fails++; $display("FAIL edit_inc_vc%0d: got %b expected %b", k, value_changed, m_vc); end
         idle(99);
      end
      tests++; if (dut_vc_cnt !== mod_vc_cnt) begin fails++; $display("FAIL edit_vc_count: got %0d expected %0d", dut_vc_cnt, mod_vc_cnt); end
   endtask

   task automatic test_dec_clamp();
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0);
         tests++; if (sel_value !== VW'(m_params[m_sel])) begin fails++; $display("FAIL dec%0d: got %0d expected %0d", k, sel_value, m_params[m_sel]); end
         tests++; if (value_changed !== m_vc) begin fails++; $display("FAIL dec_vc%0d: got %b expected %b", k, value_changed, m_vc); end
         idle(9);
      end
   endtask

   task automatic test_upper_clamp();
      while (m_params[m_sel] <= 245) begin
         tick(1'b1, 1'b1);
         idle(9);
      end
      idle(90);
      while (m_params[m_sel] < 250) begin
         tick(1'b1, 1'b1);
         idle(99);
      end
      tests++; if (sel_value !== VW'(m_params[m_sel])) begin fails++; $display("FAIL upper_start: got %0d expected %0d", sel_value, m_params[m_sel]); end
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b1);
         tests++; if (sel_value !== VW'(m_params[m_sel])) begin fails++; $display("FAIL upper%0d: got %0d expected %0d", k, sel_value, m_params[m_sel]); end
         tests++; if (value_changed !== m_vc) begin fails++; $display("FAIL upper_vc%0d: got %b expected %b", k, value_changed, m_vc); end
         idle(9);
      end
   endtask

   task automatic test_bounce_long();
      for (int k = 0; k < 12; k++) begin
         btn_lvl = (k % 2 == 0);
         idle(5);
      end
      btn_lvl = 1'b1;
      idle(1200);
      tests++; if (param_bus !== model_bus()) begin fails++; $display("FAIL long_bus: got %h expected %h", param_bus, model_bus()); end
      btn_lvl = 1'b0;
      idle(60);
      tests++; if (sel_value !== VW'(m_params[m_sel])) begin fails++; $display("FAIL long_selval: got %0d expected %0d", sel_value, m_params[m_sel]); end
      tests++; if (edit_mode !== m_edit) begin fails++; $display("FAIL long_mode: got %b expected %b", edit_mode, m_edit); end
      tests++; if (dut_vc_cnt !== mod_vc_cnt) begin fails++; $display("FAIL long_vc: got %0d expected %0d", dut_vc_cnt, mod_vc_cnt); end
   endtask

   task automatic test_timeout();
      logic prev;
      int   n;
      if (m_edit) press(50);
      press(50);
      tests++; if (edit_mode !== m_edit) begin fails++; $display("FAIL tmo_enter: got %b expected %b", edit_mode, m_edit); end
      prev = edit_mode;
      n = 0;
      while (m_edit && n < 400) begin
         prev = edit_mode;
         tick(1'b0, 1'b0);
         n++;
      end
      tests++; if (m_edit) begin fails++; $display("FAIL tmo_bound: got no timeout in %0d cycles expected one", n); end
      tests++; if (prev !== 1'b1) begin fails++; $display("FAIL tmo_early: got %b before expiry expected 1", prev); end
      tests++; if (edit_mode !== 1'b0) begin fails++; $display("FAIL tmo_exit: got %b expected 0", edit_mode); end
   endtask

   task automatic test_random();
      int gap, hold;
      for (int op = 0; op < 40; op++) begin
         if ($urandom_range(0, 4) != 0) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            gap = $urandom_range(1, 260);
            idle(gap);
         end else begin
            hold = $urandom_range(20, 90);
            btn_lvl = 1'b1;
            for (int i = 0; i < hold; i++) tick($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
            btn_lvl = 1'b0;
            for (int i = 0; i < 40; i++) tick($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
         end
         tests++; if (sel !== m_sel[1:0]) begin fails++; $display("FAIL rnd_sel%0d: got %0d expected %0d", op, sel, m_sel); end
         tests++; if (edit_mode !== m_edit) begin fails++; $display("FAIL rnd_mode%0d: got %b expected %b", op, edit_mode, m_edit); end
         tests++; if (param_bus !== model_bus()) begin fails++; $display("FAIL rnd_bus%0d: got %h expected %h", op, param_bus, model_bus()); end
         tests++; if (dut_vc_cnt !== mod_vc_cnt) begin fails++; $display("FAIL rnd_vc%0d: got %0d expected %0d", op, dut_vc_cnt, mod_vc_cnt); end
      end
   endtask

   task automatic test_reset_mid_hold();
      if (!m_edit) press(50);
      tick(1'b1, 1'b1);
      idle(9);
      tick(1'b1, 1'b1);
      btn_lvl = 1'b1;
      idle(300);
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (sel !== 2'd0) begin fails++; $display("FAIL arst_sel: got %0d expected 0", sel); end
      tests++; if (edit_mode !== 1'b0) begin fails++; $display("FAIL arst_mode: got %b expected 0", edit_mode); end
      tests++; if (param_bus !== '0) begin fails++; $display("FAIL arst_bus: got %h expected 0", param_bus); end
      tests++; if (value_changed !== 1'b0) begin fails++; $display("FAIL arst_vc: got %b expected 0", value_changed); end
      apply_reset();
      idle(1100);
      tests++; if (edit_mode !== m_edit) begin fails++; $display("FAIL arst_after_mode: got %b expected %b", edit_mode, m_edit); end
      tests++; if (param_bus !== model_bus()) begin fails++; $display("FAIL arst_after_bus: got %h expected %h", param_bus, model_bus()); end
      tests++; if (dut_vc_cnt !== mod_vc_cnt) begin fails++; $display("FAIL arst_after_vc: got %0d expected %0d", dut_vc_cnt, mod_vc_cnt); end
   endtask

   initial begin
      btn_lvl = 1'b0;
      model_reset();
      test_reset();
      test_browse();
      test_short_edit();
      test_dec_clamp();
      test_upper_clamp();
      test_bounce_long();
      test_timeout();
      test_random();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/encoder_param_ctrl.md
Name: encoder_param_ctrl

Overview:
Parameter-editing controller driven by the quadrature step decoder (one-cycle step pulse plus direction) and a push button on the encoder shaft. In BROWSE, detents move a selection cursor across N_PARAMS registers. In EDIT, detents change the selected register with clamping and speed acceleration. A button short press toggles mode; a long press restores the selected register's default. All parameter values are exported as a flat bus for downstream configuration logic.

Parameters:
N_PARAMS, 4, number of parameter registers (power of two, >=2)
VAL_W, 8, width of each parameter value
MAX_VAL, 255, upper clamp for values; lower clamp is 0
DEFAULT_VAL, 0, reset and long-press restore value
DEBOUNCE_CYC, 16, cycles the synchronised button level must be stable before it is accepted
LONG_PRESS_CYC, 1000, debounced hold cycles that constitute a long press
FAST_WIN_CYC, 64, inter-step gap (cycles) below which acceleration applies
ACCEL, 4, step magnitude when accelerated (1 otherwise)
TIMEOUT_CYC, 4096, EDIT inactivity timeout in cycles; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
step_valid  in  1  one-cycle pulse per decoded encoder step
step_dir  in  1  1 = clockwise (increment), 0 = decrement; valid with step_valid
btn_raw  in  1  raw push button, active high, asynchronous to clk
sel  out  log2(N_PARAMS)  currently selected parameter index
edit_mode  out  1  0 = BROWSE, 1 = EDIT
sel_value  out  VAL_W  value of the selected register (combinational mux of registers)
param_bus  out  N_PARAMS*VAL_W  all values; param i at bits [i*VAL_W +: VAL_W]
value_changed  out  1  one-cycle pulse when any register value actually changes

Behaviour:
- Reset state: all params = DEFAULT_VAL; sel = 0; edit_mode = 0; value_changed = 0; gap counter saturated (first step is never accelerated); timeout counter = 0; debouncer level = 0; hold counter = 0.
- Button path:
  - btn_raw passes through a 2-FF synchroniser.
  - The debounced level updates when the synchronised value has differed from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
  - On a debounced rising edge, the hold counter starts.
  - Hold counter reaches LONG_PRESS_CYC while held -> one-cycle LONG event; the subsequent release generates nothing.
  - Release before LONG_PRESS_CYC -> one-cycle SHORT event on the falling-edge cycle.
- State machine, BROWSE/EDIT:
  - SHORT toggles the mode.
  - LONG sets params[sel] = DEFAULT_VAL in either mode; mode is unchanged. value_changed pulses only if the old value differed.
  - In EDIT, if TIMEOUT_CYC != 0 and the timeout counter reaches TIMEOUT_CYC -> BROWSE.
  - The timeout counter clears on any step_valid or button event and counts only in EDIT.
- Step handling in BROWSE:
  - sel += 1 if step_dir, else sel -= 1, modulo N_PARAMS (wraps both ways).
  - No value change and no acceleration in this mode.
- Step handling in EDIT:
  - delta = ACCEL if gap < FAST_WIN_CYC, else 1.
  - gap is the saturating count of cycles since the previous EDIT step. It clears on each EDIT step and saturates on entry to EDIT.
  - Increment: new = min(val + delta, MAX_VAL). Compute at VAL_W+1 bits so there is no overflow wrap.
  - Decrement: new = (val < delta) ? 0 : val - delta.
  - At a clamp the value holds and value_changed stays 0.
- Latency:
  - step_valid in cycle n -> sel / params / value_changed updated at the edge ending cycle n, visible in cycle n+1.
  - Button events take the same one-cycle latency after the event cycle.
- Simultaneous events: a button event (SHORT or LONG) and step_valid in the same cycle -> the button event is processed and the step is discarded. A timeout and a step in the same cycle -> the step is applied and the timeout is cancelled.
- Asynchronous reset mid-hold or mid-edit returns to the reset state; no pending event survives it.

Decomposition:
- Shared package encoder_ctrl_pkg holds:
  - mode_t enum {MODE_BROWSE, MODE_EDIT};
  - btn_evt_t enum {EVT_NONE, EVT_SHORT, EVT_LONG};
  - a helper function for the clamped add/subtract.
- One sub-module, button_debounce: synchroniser, debounce, and hold counter, emitting btn_evt_t. Parameters DEBOUNCE_CYC and LONG_PRESS_CYC. Same clk/rst_n.

Test Plan:
- Reset, then 5 CW steps spaced 100 cycles, in BROWSE with N_PARAMS=4 -> sel goes 1,2,3,0,1; params unchanged; value_changed never pulses.
- Clean short press (held 50 cycles, DEBOUNCE_CYC=16) -> edit_mode=1 on release. Then 3 CW steps spaced 100 cycles -> sel_value 0->1->2->3 with 3 value_changed pulses.
- In EDIT with val=3: 2 CCW steps spaced 10 cycles -> first 3->2 (delta 1), second 2->0 (clamped, ACCEL=4). A third fast CCW step leaves 0 and value_changed=0.
- With val=250 and MAX_VAL=255: fast CW steps -> 251 then 255, then holds at 255 with no pulse.
- Button bouncing (toggling every 5 cycles for 60 cycles, then stable high 1200 cycles) -> exactly one LONG event; params[sel]=DEFAULT_VAL; mode unchanged; no SHORT on release.
- In EDIT with TIMEOUT_CYC=200 and no activity -> edit_mode=0 after 200 cycles. Assert rst_n low mid-hold -> all outputs at reset values immediately.
